// File: rtl/result_fifo.sv
// Result FIFO between the engine and the accelerator controller.
// Registered pop output with a one-cycle valid pulse and sticky overflow/underflow flags.
module result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       writeReq,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       readReq,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic w_empty;
    logic w_full;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // A pop frees a slot in the same edge, so a full FIFO can still take a write alongside it.
    assign w_rd_acc = readReq && !w_empty && !clr;
    assign w_wr_acc = writeReq && (!w_full || w_rd_acc) && !clr;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + AW'(1);
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - CW'(1);
            end
            if (writeReq && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (readReq && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: doc/result_fifo.md
RESULT_FIFO -- requirements
Module: result_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the bit width of one engine result word.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the number of entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, an asynchronous active-low reset (asserted when 0).
REQ-005 SHALL have port clr, input, 1 bit, a synchronous flush of the pointers, count and sticky flags.
REQ-006 SHALL have port writeReq, input, 1 bit, a one-cycle write strobe from the accelerator controller.
REQ-007 SHALL have port wr_data, input, WIDTH bits, the engine result sampled when writeReq=1.
REQ-008 SHALL have port readReq, input, 1 bit, a one-cycle pop strobe from the accelerator controller.
REQ-009 SHALL have port rd_data, output, WIDTH bits, the registered head word of the last accepted pop.
REQ-010 SHALL have port rd_valid, output, 1 bit, pulsed for one cycle when rd_data is updated.
REQ-011 SHALL have port empty, output, 1 bit, asserted when count is 0.
REQ-012 SHALL have port full, output, 1 bit, asserted when count equals DEPTH.
REQ-013 SHALL have port count, output, log2(DEPTH)+1 bits, the number of stored entries.
REQ-014 SHALL have port overflow, output, 1 bit, a sticky flag for a dropped write.
REQ-015 SHALL have port underflow, output, 1 bit, a sticky flag for an ignored read.

Function
REQ-016 SHALL accept a write when writeReq=1 and either full=0 or a read is accepted in the same cycle: storage[wr_ptr] gets wr_data and wr_ptr increments.
REQ-017 SHALL accept a read when readReq=1 and empty=0: rd_data gets storage[rd_ptr] on the same edge, rd_valid=1 in the next cycle only, and rd_ptr increments.
REQ-018 SHALL provide read latency of exactly 1 cycle from the readReq edge to rd_valid/rd_data, with no fall-through: a word written in cycle N is poppable from cycle N+1.
REQ-019 SHALL wrap wr_ptr and rd_ptr modulo DEPTH (log2(DEPTH) bits each); count SHALL be tracked separately and never wrap.
REQ-020 SHALL update count as follows:
- +1 on write only.
- -1 on read only.
- Unchanged on a simultaneous accepted write and read.
REQ-021 SHALL, when full and both strobes are high, accept both: the head is popped, the new word is stored, count stays at DEPTH, and overflow is not set.
REQ-022 SHALL, when empty and both strobes are high, accept the write and ignore the read: count becomes 1, rd_valid stays 0, and underflow is set.
REQ-023 SHALL, on writeReq=1 with full=1 and no accepted read, drop the data, leave the pointers unchanged, and set overflow.
REQ-024 SHALL, on readReq=1 with empty=1, leave rd_data unchanged, keep rd_valid=0, and set underflow.
REQ-025 SHALL hold overflow and underflow until clr=1 or reset; clr SHALL take priority over any simultaneous read or write (both strobes ignored that cycle).
REQ-026 SHALL derive empty and full combinationally from the registered count, so they change in the cycle after the causing edge.
REQ-027 SHALL hold rd_data at its last popped value between pops.
REQ-028 SHALL not reset or clear the storage array; its contents are don't-care until written.

Reset
REQ-029 SHALL, while rst=0, force asynchronously:
- wr_ptr=0, rd_ptr=0, count=0.
- rd_data=0, rd_valid=0.
- overflow=0, underflow=0.
- Hence empty=1, full=0.
REQ-030 SHALL abandon any in-flight pop when reset is asserted mid-operation (rd_valid not asserted afterward); the first edge after deassertion behaves as from an empty FIFO.

Verification
REQ-031 SHALL cover sequential fill and drain: write 8 words 0x0001..0x0008, then 8 reads -> rd_data 0x0001..0x0008 in order, each with a 1-cycle rd_valid pulse; full=1 after the 8th write; empty=1 after the 8th read.
REQ-032 SHALL cover overflow: with the FIFO full, write 0xBEEF -> overflow=1 and count=8; a subsequent drain never returns 0xBEEF.
REQ-033 SHALL cover underflow and pointer wrap:
- From reset, readReq -> underflow=1, rd_valid=0, rd_data=0.
- Then 12 write/read pairs spaced one cycle apart -> correct data across the pointer wrap.
REQ-034 SHALL cover simultaneous strobes:
- Full plus both strobes -> count stays 8, the head is returned, the new word is appended at the tail.
- Empty plus both strobes -> count=1, underflow=1.
REQ-035 SHALL cover clr and reset:
- With 5 entries and both flags set, clr=1 for one cycle -> count=0, empty=1, flags=0, and a same-cycle writeReq is ignored.
- rst=0 asserted mid-pop -> rd_valid=0 immediately and all outputs at their reset values.
